// File: rtl/mem_ctrl.sv
// mem_ctrl: initiator-side sequencer for the 512x32 RAM (single-word rd/wr).
// Optional address bounds check enabled by defining MEM_CTRL_BOUNDS_EN.
//
// Ports:
//   clk, clr          clock (rising edge), async active-low reset
//   req_rd, req_wr    request strobes, sampled only while idle (write wins)
//   req_addr/wdata    MAR / MDR values latched on acceptance
//   busy, done, err   status: busy SETUP..DONE, one-cycle done / reject pulse
//   rdata             captured read data (internal MDR)
//   ram_*             RAM strobes, address, write data and read data
module mem_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_LIMIT  = 511
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

`ifdef MEM_CTRL_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0] LIMIT    = (ADDR_W + 1)'(ADDR_LIMIT);
    localparam logic [3:0]      CNT_LOAD = 4'(WAIT_CYCLES - 1);

    // S_ACPT is the cycle after the sampling edge: the latched address and
    // data are already on the RAM pins, so they lead the strobe by two
    // cycles and done lands 3+WAIT_CYCLES cycles after the request.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACPT,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic req_any;
    logic oob;
    logic accept;
    logic capture;

    assign req_any = req_rd | req_wr;
    assign oob     = BOUNDS_EN && ({1'b0, req_addr} > LIMIT);
    assign accept  = (state_q == S_IDLE) && req_any && !oob;
    assign capture = (state_q == S_ACCESS) && (cnt_q == 4'd0) && !op_wr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_ACPT;
            S_ACPT:   state_d = S_SETUP;
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = CNT_LOAD;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = (state_q == S_IDLE) && req_any && oob;
        if (accept) begin
            op_wr_d = req_wr;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
        if (capture) rdata_d = ram_rdata;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from the state register so an async reset
    // drops them at once; op_wr_q keeps them mutually exclusive.
    assign busy      = (state_q == S_SETUP) || (state_q == S_ACCESS) ||
                       (state_q == S_DONE);
    assign done      = (state_q == S_DONE);
    assign ram_read  = (state_q == S_ACCESS) && !op_wr_q;
    assign ram_write = (state_q == S_ACCESS) && op_wr_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule
